// File: rtl/uart_phy.sv
// uart_phy: bit-level 8N1 UART engine (1 start, 8 data LSB-first, 1 stop),
// idle-high line, CLK_DIV clocks per bit. TX and RX run independently.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - asynchronous, active-high
//   tx_req    - one-cycle transmit request, tx_data sampled in the same cycle
//   tx_data   - byte to transmit
//   rx        - serial input, asynchronous to clk
//   tx        - serial output
//   rx_data   - last good received byte, held until the next good byte
//   tx_ready  - one-cycle pulse in the last cycle of the stop bit
//   rx_ready  - one-cycle pulse, rx_data valid this cycle
//   rx_ferr   - one-cycle pulse, stop bit sampled low
module uart_phy #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       tx_ready,
  output logic       rx_ready,
  output logic       rx_ferr
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'((CLK_DIV >> 1) - 1);

  // ---------------------------------------------------------------- TX ----
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t       tx_state, tx_next;
  logic [CW-1:0]   tx_cnt;
  logic [2:0]      tx_bit;
  logic [7:0]      tx_sh;
  logic            tx_last;

  assign tx_last = (tx_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_req) tx_next = TX_START;
      TX_START: if (tx_last) tx_next = TX_DATA;
      TX_DATA:  if (tx_last && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_last) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // tx is decoded from state so that reset forces the line high immediately.
  always_comb begin
    tx       = 1'b1;
    tx_ready = 1'b0;
    case (tx_state)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = tx_sh[0];
      TX_STOP:  tx_ready = tx_last;
      default:  tx = 1'b1;
    endcase
  end

  // Shift register loads only in IDLE, so requests during a frame are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else if (tx_state == TX_IDLE) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      if (tx_req) tx_sh <= tx_data;
    end else begin
      tx_cnt <= tx_last ? '0 : tx_cnt + CW'(1);
      if (tx_state == TX_DATA && tx_last) begin
        tx_sh  <= {1'b0, tx_sh[7:1]};
        tx_bit <= tx_bit + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------- RX ----
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  rx_state_t       rx_state, rx_next;
  logic            rx_m, rx_s;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_sh;
  logic            rx_last, rx_half;
  logic            rx_sample, rx_good, rx_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign rx_last = (rx_cnt == LAST);
  assign rx_half = (rx_cnt == HALF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:      if (!rx_s) rx_next = RX_START;
      RX_START:     if (rx_half) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_last && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:      if (rx_last) rx_next = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_s) rx_next = RX_IDLE;
      default:      rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_sample = (rx_state == RX_DATA) && rx_last;
    rx_good   = (rx_state == RX_STOP) && rx_last && rx_s;
    rx_bad    = (rx_state == RX_STOP) && rx_last && !rx_s;
  end

  // Counter restarts at the start-bit centre, so every later sample lands
  // CLK_DIV cycles apart at bit centres.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_ready <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_ready <= rx_good;
      rx_ferr  <= rx_bad;
      if (rx_good) rx_data <= rx_sh;
      case (rx_state)
        RX_START: rx_cnt <= rx_half ? '0 : rx_cnt + CW'(1);
        RX_DATA,
        RX_STOP:  rx_cnt <= rx_last ? '0 : rx_cnt + CW'(1);
        default:  rx_cnt <= '0;
      endcase
      if (rx_state == RX_IDLE) rx_bit <= '0;
      else if (rx_sample)      rx_bit <= rx_bit + 3'd1;
      if (rx_sample) rx_sh <= {rx_s, rx_sh[7:1]};
    end
  end

endmodule

// File: doc/uart_phy.md
# uart_phy

Bit-level UART engine sitting underneath the `serial` peripheral: serializes one byte per `tx_req` onto `tx` and deserializes frames arriving on `rx`. It answers the peripheral's transmit handshake (`tx_req`/`tx_ready`) and drives its receive push (`rx_ready`/`rx_data`). Frame format is fixed 8N1 (1 start, 8 data LSB-first, 1 stop), idle-high, at `CLK_DIV` clocks per bit.

## Interface
- `CLK_DIV`, default 434: clock cycles per bit (50 MHz / 115200). Legal range ≥ 4. Bit counters are `$clog2(CLK_DIV)` bits wide.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `tx_req` input 1: single-cycle transmit request; `tx_data` sampled in the same cycle.
- `tx_data` input 8: byte to send.
- `rx` input 1: serial line in, asynchronous to `clk`.
- `tx` output 1: serial line out.
- `rx_data` output 8: last good received byte, held until the next good byte.
- `tx_ready` output 1: one-cycle pulse, frame fully sent.
- `rx_ready` output 1: one-cycle pulse, `rx_data` valid this cycle.
- `rx_ferr` output 1: one-cycle pulse, framing error (stop bit sampled low).

## Operation
- Reset values: `tx`=1, `tx_ready`=0, `rx_ready`=0, `rx_ferr`=0, `rx_data`=8'h00, both FSMs in IDLE, counters 0. Reset mid-frame abandons the frame; `tx` returns high asynchronously.
- TX FSM: IDLE → START → DATA(×8) → STOP → IDLE.
  - IDLE: `tx`=1. `tx_req`=1 latches `tx_data` into the shift register and enters START.
  - `tx_req` outside IDLE is ignored; the latched byte is unaffected.
  - Each state after IDLE lasts exactly `CLK_DIV` cycles. START drives 0. DATA drives shift bit 0 and shifts right after each bit. STOP drives 1.
  - `tx_ready` pulses in the last cycle of STOP; the FSM is in IDLE on the next cycle.
- RX path: `rx` passes through a 2-flop synchronizer (`rx_s`); all decisions use `rx_s`.
- RX FSM: IDLE → START → DATA(×8) → STOP → IDLE, plus WAIT_HIGH.
  - IDLE: `rx_s`=0 enters START and clears the counter.
  - START: after `CLK_DIV>>1` cycles, sample `rx_s`. If 1, it was a glitch; return to IDLE with no pulse. If 0, enter DATA.
  - DATA: sample every `CLK_DIV` cycles at bit centre; shift in LSB-first.
  - STOP: sample `CLK_DIV` cycles after the bit-7 sample.
    - Sample = 1: load `rx_data` and pulse `rx_ready` in the next cycle, then IDLE.
    - Sample = 0: pulse `rx_ferr`, leave `rx_data` unchanged, no `rx_ready`, enter WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then IDLE. This prevents a break condition from retriggering frames.
- TX and RX are fully independent. Simultaneous `tx_ready` and `rx_ready` pulses are legal.

## Timing
- Request accepted at cycle T:
  - `tx` falls at T+1.
  - Data bit k occupies cycles T+1+(k+1)·CLK_DIV … T+(k+2)·CLK_DIV.
  - `tx_ready`=1 at cycle T+10·CLK_DIV.
- A new `tx_req` is accepted at T+10·CLK_DIV+1 or later.
  - Back-to-back frames have no extra idle bits beyond the requester's own latency.
- RX latency: `rx_ready` occurs 2 (sync) + (CLK_DIV>>1) + 9·CLK_DIV + 1 cycles after the start edge on `rx`, ±1 cycle of sync uncertainty.
- Bit-period error tolerance: a mid-bit sample stays inside the bit for up to ±4% clock mismatch at CLK_DIV ≥ 16.
- `rx_data` changes only in the same cycle `rx_ready` is 1.

## Test plan
- Reset, then CLK_DIV=16 and `tx_req` with 8'hA5 at T → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each held 16 cycles starting T+1; single `tx_ready` at T+160; `tx`=1 afterwards.
- Loop `tx`→`rx`, send 8'h00, 8'hFF, 8'h55, then all 256 values back-to-back, issuing `tx_req` the cycle after each `tx_ready` → `rx_ready` pulses once per byte with matching `rx_data`; no `rx_ferr`.
- Pull `rx` low for 5 cycles (CLK_DIV=16) → no `rx_ready`, no `rx_ferr`. A valid 8'h3C frame following it is received correctly.
- Drive a frame 8'h81 with stop bit 0, then hold `rx` low 40 cycles → one `rx_ferr` pulse, `rx_data` keeps its previous value, no further frames until `rx` rises. A subsequent valid 8'h7E is received.
- Pulse `tx_req` with 8'h12 during a frame carrying 8'hC3 → 8'hC3 transmitted intact, exactly one `tx_ready`, 8'h12 never sent.
- Assert `reset` mid-frame on both TX and RX → `tx`=1 immediately, no `tx_ready`/`rx_ready`/`rx_ferr`. After release, the next 8'h5A transfer completes normally.
